// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg
// Shared CPU constants for the writeback stage: default data and register
// address widths, the register count and the starvation counter width.
// No ports; imported by wb_arbiter and wb_scoreboard.
package wb_arbiter_pkg;

  localparam int DW_DEFAULT   = 32;
  localparam int AW_DEFAULT   = 5;
  localparam int STARVE_CNT_W = 4;

  // Number of architectural registers addressed by an aw-bit index.
  function automatic int reg_count(input int aw);
    return 1 << aw;
  endfunction

  localparam int NUM_REGS = reg_count(AW_DEFAULT);

  typedef logic [STARVE_CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
// Pending-write bit vector, one bit per register. A bit is set when decode
// issues an instruction that will write the register and cleared when the
// writeback commits that register. Two combinational check ports let decode
// detect RAW hazards.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   set_en, set_addr      mark a register as pending
//   clr_en, clr_addr      retire a pending register
//   chk_addr1/2           registers to test
//   stall1/2              pending bit of chk_addr1/2
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          stall1,
  output logic          stall2
);

  localparam int NREGS = reg_count(AW);

  logic [NREGS-1:0] pend_q, pend_d;

  // Clear is applied before set so that an issue and a commit to the same
  // register on the same edge leave the bit pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign stall1 = pend_q[chk_addr1];
  assign stall2 = pend_q[chk_addr2];

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Writeback stage in front of the register file. Arbitrates ALU and load
// results onto the single write port (loads have priority, ALU is force-granted
// after STARVE_LIMIT consecutive denials), registers the write and keeps the
// pending-write scoreboard used by decode for RAW hazard stalls.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   issue_valid, issue_addr             decode issue marking a pending write
//   alu_valid/ready/addr/data           ALU result handshake
//   mem_valid/ready/addr/data           load result handshake
//   write, write_addr, write_data       registered register-file write
//   chk_addr1/2, stall1/2               hazard check ports
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int AW           = AW_DEFAULT,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_GUARD   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_addr,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          write,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  input  logic [AW-1:0] chk_addr1,
  input  logic [AW-1:0] chk_addr2,
  output logic          stall1,
  output logic          stall2
);

  starve_cnt_t   starve_q, starve_d;
  logic          write_q, write_d;
  logic [AW-1:0] write_addr_q, write_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic          force_alu;
  logic          alu_xfer;
  logic          mem_xfer;
  logic [AW-1:0] xfer_addr;
  logic [DW-1:0] xfer_data;
  logic          addr_guarded;
  logic          issue_set;

  // Arbitration and next-state. The two grants are mutually exclusive: when
  // the ALU is forced the load is held off, otherwise the ALU only gets the
  // port when no load is waiting. Writes to r0 still complete the handshake
  // but never reach the register file; the output address/data hold.
  always_comb begin
    force_alu    = (starve_q == starve_cnt_t'(STARVE_LIMIT));
    mem_ready    = !force_alu;
    alu_ready    = force_alu || !mem_valid;
    alu_xfer     = alu_valid && alu_ready;
    mem_xfer     = mem_valid && mem_ready;

    xfer_addr    = mem_xfer ? mem_addr : alu_addr;
    xfer_data    = mem_xfer ? mem_data : alu_data;
    addr_guarded = (ZERO_GUARD != 0) && (xfer_addr == '0);

    write_d      = (alu_xfer || mem_xfer) && !addr_guarded;
    write_addr_d = write_d ? xfer_addr : write_addr_q;
    write_data_d = write_d ? xfer_data : write_data_q;

    // A count can never pass STARVE_LIMIT because reaching it grants the ALU.
    starve_d = starve_q;
    if (!alu_valid || alu_xfer) starve_d = '0;
    else                        starve_d = starve_q + 1'b1;

    issue_set = issue_valid && !((ZERO_GUARD != 0) && (issue_addr == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      starve_q     <= starve_d;
      write_q      <= write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign write      = write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

  // The pending bit clears on the same edge the register file commits.
  wb_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_set),
    .set_addr (issue_addr),
    .clr_en   (write_q),
    .clr_addr (write_addr_q),
    .chk_addr1(chk_addr1),
    .chk_addr2(chk_addr2),
    .stall1   (stall1),
    .stall2   (stall2)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
// Directed bench for wb_arbiter. Each cycle the expected register-file write
// is derived from the driven inputs and the expected grants, queued, and
// compared one edge later against the registered write outputs.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          write;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          stall1;
  logic          stall2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [AW-1:0] held_addr = '0;
  logic [DW-1:0] held_data = '0;

  wb_arbiter #(
    .DW(DW), .AW(AW), .STARVE_LIMIT(4), .ZERO_GUARD(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .write      (write),
    .write_addr (write_addr),
    .write_data (write_data),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .stall1     (stall1),
    .stall2     (stall2)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the clocking misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [AW-1:0] ia,
                               input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    issue_valid = iv;
    issue_addr  = ia;
    alu_valid   = av;
    alu_addr    = aa;
    alu_data    = ad;
    mem_valid   = mv;
    mem_addr    = ma;
    mem_data    = md;
  endtask

  task automatic setChk(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    chk_addr1 = a1;
    chk_addr2 = a2;
    #1;
  endtask

  // One clock cycle: check grants mid-cycle, queue the expected write, then
  // compare the registered write just after the edge.
  task automatic checkOutput(input string tag, input logic exp_ar, input logic exp_mr);
    wr_t  e;
    wr_t  got;
    logic xa;
    logic xm;
    @(negedge clk);
    chk({tag, "/alu_ready"}, DW'(alu_ready), DW'(exp_ar));
    chk({tag, "/mem_ready"}, DW'(mem_ready), DW'(exp_mr));
    xa = alu_valid && exp_ar;
    xm = mem_valid && exp_mr;
    e  = '{wr: 1'b0, addr: held_addr, data: held_data};
    if (xm && mem_addr != '0)      e = '{wr: 1'b1, addr: mem_addr, data: mem_data};
    else if (!xm && xa && alu_addr != '0) e = '{wr: 1'b1, addr: alu_addr, data: alu_data};
    if (e.wr) begin
      held_addr = e.addr;
      held_data = e.data;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, "/write"},      DW'(write),      DW'(got.wr));
    chk({tag, "/write_addr"}, DW'(write_addr), DW'(got.addr));
    chk({tag, "/write_data"}, write_data,      got.data);
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, '0, 0, '0, '0, 0, '0, '0);
    checkOutput(tag, 1'b1, 1'b1);
  endtask

  initial begin
    applyStimulus(0, '0, 0, '0, '0, 0, '0, '0);
    chk_addr1 = 5'd9;
    chk_addr2 = 5'd0;
    #2;
    chk("reset/write",      DW'(write),      '0);
    chk("reset/write_addr", DW'(write_addr), '0);
    chk("reset/write_data", write_data,      '0);
    chk("reset/stall1",     DW'(stall1),     '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ALU result, then an idle cycle where write drops and data holds.
    applyStimulus(0, '0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    checkOutput("alu_single", 1'b1, 1'b1);
    idle("alu_single_idle");

    // Both producers: load first, ALU the next cycle.
    applyStimulus(0, '0, 1, 5'd7, 32'h77, 1, 5'd3, 32'h33);
    checkOutput("both_mem", 1'b0, 1'b1);
    applyStimulus(0, '0, 1, 5'd7, 32'h77, 0, '0, '0);
    checkOutput("both_alu", 1'b1, 1'b1);
    idle("both_idle");

    // Starvation: four denials, forced grant on the fifth cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 5'd12, 32'hA1, 1, 5'(10 + i), 32'h100 + i);
      checkOutput($sformatf("starve_deny%0d", i), 1'b0, 1'b1);
    end
    applyStimulus(0, '0, 1, 5'd12, 32'hA1, 1, 5'd15, 32'h1FF);
    checkOutput("starve_grant", 1'b1, 1'b0);
    applyStimulus(0, '0, 1, 5'd13, 32'hA2, 1, 5'd15, 32'h1FF);
    checkOutput("starve_cleared", 1'b0, 1'b1);
    idle("starve_idle");

    // Scoreboard hazard on r9.
    applyStimulus(1, 5'd9, 0, '0, '0, 0, '0, '0);
    setChk(5'd9, 5'd4);
    checkOutput("issue9", 1'b1, 1'b1);
    chk("hazard/stall1_set", DW'(stall1), 32'd1);
    chk("hazard/stall2_other", DW'(stall2), 32'd0);
    setChk(5'd4, 5'd9);
    chk("hazard/stall2_set", DW'(stall2), 32'd1);
    setChk(5'd9, 5'd4);
    applyStimulus(0, '0, 1, 5'd9, 32'h99, 0, '0, '0);
    checkOutput("write9", 1'b1, 1'b1);
    chk("hazard/stall_during_write", DW'(stall1), 32'd1);
    idle("hazard_commit");
    chk("hazard/stall1_cleared", DW'(stall1), 32'd0);

    // Issue and commit of r9 on the same edge: set wins.
    applyStimulus(1, 5'd9, 0, '0, '0, 0, '0, '0);
    checkOutput("reissue9", 1'b1, 1'b1);
    applyStimulus(0, '0, 1, 5'd9, 32'h98, 0, '0, '0);
    checkOutput("rewrite9", 1'b1, 1'b1);
    applyStimulus(1, 5'd9, 0, '0, '0, 0, '0, '0);
    checkOutput("same_edge", 1'b1, 1'b1);
    chk("same_edge/stall1", DW'(stall1), 32'd1);
    idle("same_edge_idle");
    chk("same_edge/stall1_hold", DW'(stall1), 32'd1);

    // Zero guard: r0 handshake completes but nothing is written or tracked.
    applyStimulus(0, '0, 1, 5'd0, 32'h1, 0, '0, '0);
    checkOutput("zero_alu", 1'b1, 1'b1);
    applyStimulus(1, 5'd0, 0, '0, '0, 0, '0, '0);
    setChk(5'd0, 5'd4);
    checkOutput("zero_issue", 1'b1, 1'b1);
    chk("zero/stall1", DW'(stall1), 32'd0);

    // Reset while a write is on the port.
    setChk(5'd9, 5'd9);
    applyStimulus(0, '0, 1, 5'd20, 32'h2020, 0, '0, '0);
    checkOutput("pre_reset", 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset/write",      DW'(write),      '0);
    chk("midreset/write_addr", DW'(write_addr), '0);
    chk("midreset/write_data", write_data,      '0);
    chk("midreset/stall1",     DW'(stall1),     '0);
    chk("midreset/stall2",     DW'(stall2),     '0);
    held_addr = '0;
    held_data = '0;
    applyStimulus(0, '0, 0, '0, '0, 0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, '0, 1, 5'd21, 32'h2121, 0, '0, '0);
    checkOutput("post_reset", 1'b1, 1'b1);
    idle("post_reset_idle");

    chk("queue_empty", DW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
